axis_insert_arbiter: RTL
========================

Name: axis_insert_arbiter

Overview:
Packet-level round-robin arbiter that shares one axi_stream_insert_header instance between NUM_SRC requesters. Each requester owns a data stream (valid/data/keep/last) and a header stream (valid/header/keep). The block grants one requester per packet and routes both of its streams to the inserter's data and header inputs. The grant is held until the packet's last beat and its header have both been accepted.

Parameters:
NUM_SRC, 2, number of requesters (2..8)
DATA_WD, 32, data and header width in bits
DATA_BYTE_WD, DATA_WD/8, keep width
ID_WD, (NUM_SRC>1 ? $clog2(NUM_SRC) : 1), grant_id width

Ports:
clk  in  1  clock
rst_n  in  1  reset
s_valid_in  in  NUM_SRC  per-source data valid
s_data_in  in  NUM_SRC*DATA_WD  per-source data; source i at [i*DATA_WD +: DATA_WD]
s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source data keep
s_last_in  in  NUM_SRC  per-source last
s_ready_in  out  NUM_SRC  per-source data ready
s_valid_insert  in  NUM_SRC  per-source header valid
s_header_insert  in  NUM_SRC*DATA_WD  per-source header
s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep
s_ready_insert  out  NUM_SRC  per-source header ready
m_valid_in  out  1  to inserter valid_in
m_data_in  out  DATA_WD  to inserter data_in
m_keep_in  out  DATA_BYTE_WD  to inserter keep_in
m_last_in  out  1  to inserter last_in
m_ready_in  in  1  from inserter ready_in
m_valid_insert  out  1  to inserter valid_insert
m_header_insert  out  DATA_WD  to inserter header_insert
m_keep_insert  out  DATA_BYTE_WD  to inserter keep_insert
m_ready_insert  in  1  from inserter ready_insert
grant_id  out  ID_WD  index of the current or last granted source
busy  out  1  high while in GRANT

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- On reset: state=IDLE, last_grant=NUM_SRC-1 (source 0 wins first), grant_id=0, busy=0, hdr_done=0, pkt_done=0.
- While in reset, all m_valid_* and s_ready_* are 0 and all m_data/keep/header outputs are 0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - Source i requests when s_valid_insert[i] & s_valid_in[i]. A header alone or data alone is not a request.
  - Winner is the first requester searching from last_grant+1 upward, wrapping modulo NUM_SRC.
  - On a winner: next cycle state=GRANT, grant_id=winner, last_grant=winner, hdr_done=0, pkt_done=0.
  - In IDLE all m_valid_* and s_ready_* are 0 and all m outputs are 0. No handshake ever occurs in IDLE.
- GRANT, with g = grant_id:
  - Header path: m_valid_insert = s_valid_insert[g] & ~hdr_done; m_header_insert and m_keep_insert are source g's header and keep; s_ready_insert[g] = m_ready_insert & ~hdr_done.
  - Data path: m_valid_in = s_valid_in[g] & ~pkt_done; m_data_in, m_keep_in and m_last_in are source g's fields; s_ready_in[g] = m_ready_in & ~pkt_done.
  - All non-granted s_ready_* are 0. Routing is combinational, so there is zero added latency in GRANT.
  - hdr_done is set on m_valid_insert & m_ready_insert.
  - pkt_done is set on m_valid_in & m_ready_in & m_last_in.
  - Exit to IDLE on the cycle where (hdr_done or header handshake now) and (pkt_done or last handshake now).
  - Header and last beat may complete in either order or in the same cycle. After a flag sets, that channel is masked: no second header is consumed and no beat of the next packet is consumed.
- Latency: request visible at cycle t gives m_valid_* at t+1. There is one idle bubble cycle between consecutive packets.
- Request changes: a source dropping its valid after the grant leaves the grant held; the source is not re-arbitrated.
- Reset mid-packet: returns to IDLE next edge with the reset values above. The partial packet is abandoned and no further beats are forwarded.
- Single-beat packet: the header and the last beat may both handshake in the first GRANT cycle, giving a return to IDLE next cycle.

Test Plan:
- Single source 0, header 0xAABBCCDD keep 4'b1110, 3 beats with last keep 4'b1100, ready_* held 1 -> grant_id=0; header and all 3 beats pass unchanged; busy high for 3 cycles; IDLE after.
- NUM_SRC=2, both sources request at cycle t -> source 0 is granted at t+1; after its last beat and one bubble, source 1 is granted; s_ready_* of source 1 stays 0 throughout source 0's packet.
- Both sources request continuously for 6 packets -> grants alternate 0,1,0,1,0,1.
- Source 1 has header valid but data not valid -> no grant, all outputs stay 0 until data arrives.
- m_ready_insert held 0 for 5 cycles while data beats flow up to last, and m_ready_in toggles 1010 -> grant held; the next packet's header and beat are not consumed; exit to IDLE the cycle after header acceptance.
- rst_n asserted on the 2nd beat of a 5-beat packet -> next cycle all m_valid=0, busy=0, grant_id=0; after release, source 0 wins first.

Source files
------------

// File: rtl/axis_insert_arbiter_if.sv
// ============================================================================
// axis_insert_arbiter_if : per-source data/header streams and inserter-side
// streams shared by the packet arbiter.  Rev 1.0
// ============================================================================
`default_nettype none

interface axis_insert_arbiter_if #(
  parameter int NUM_SRC      = 2,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic [NUM_SRC-1:0]              s_valid_in;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [NUM_SRC-1:0]              s_last_in;
  logic [NUM_SRC-1:0]              s_ready_in;
  logic [NUM_SRC-1:0]              s_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [NUM_SRC-1:0]              s_ready_insert;
  logic                            m_valid_in;
  logic [DATA_WD-1:0]              m_data_in;
  logic [DATA_BYTE_WD-1:0]         m_keep_in;
  logic                            m_last_in;
  logic                            m_ready_in;
  logic                            m_valid_insert;
  logic [DATA_WD-1:0]              m_header_insert;
  logic [DATA_BYTE_WD-1:0]         m_keep_insert;
  logic                            m_ready_insert;

  // Arbiter view: drives the inserter side and the per-source readies.
  modport master (
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_valid_insert, s_header_insert, s_keep_insert,
    output s_ready_in, s_ready_insert,
    output m_valid_in, m_data_in, m_keep_in, m_last_in,
    output m_valid_insert, m_header_insert, m_keep_insert,
    input  m_ready_in, m_ready_insert
  );

  // Environment view: requesters plus the downstream inserter.
  modport slave (
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_valid_insert, s_header_insert, s_keep_insert,
    input  s_ready_in, s_ready_insert,
    input  m_valid_in, m_data_in, m_keep_in, m_last_in,
    input  m_valid_insert, m_header_insert, m_keep_insert,
    output m_ready_in, m_ready_insert
  );
endinterface

`default_nettype wire

// File: rtl/axis_insert_arbiter.sv
// ============================================================================
// axis_insert_arbiter : packet-level round-robin arbiter feeding one header
// inserter from NUM_SRC data+header requesters.  Rev 1.0
// ============================================================================
`default_nettype none

module axis_insert_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int ID_WD        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  axis_insert_arbiter_if.master   bus,
  output logic [ID_WD-1:0]        grant_id,
  output logic                    busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [ID_WD-1:0] LAST_RST = ID_WD'(NUM_SRC - 1);

  logic [0:0]       state_q, state_d;
  logic [ID_WD-1:0] grant_q, grant_d;
  logic [ID_WD-1:0] last_grant_q, last_grant_d;
  logic             hdr_done_q, hdr_done_d;
  logic             pkt_done_q, pkt_done_d;

  logic [NUM_SRC-1:0] req;
  logic               win_found;
  logic [ID_WD-1:0]   win_id;
  logic               hs_hdr;
  logic               hs_last;

  // A request needs both the header and the first data beat present.
  assign req = bus.s_valid_insert & bus.s_valid_in;

  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_WD'(idx);
      end
    end
  end

  assign hs_hdr  = bus.m_valid_insert & bus.m_ready_insert;
  assign hs_last = bus.m_valid_in & bus.m_ready_in & bus.m_last_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      hdr_done_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hdr_done_q   <= hdr_done_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hdr_done_d   = hdr_done_q;
    pkt_done_d   = pkt_done_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d      = ST_GRANT;
          grant_d      = win_id;
          last_grant_d = win_id;
          hdr_done_d   = 1'b0;
          pkt_done_d   = 1'b0;
        end
      end
      default: begin
        if (hs_hdr)  hdr_done_d = 1'b1;
        if (hs_last) pkt_done_d = 1'b1;
        if ((hdr_done_q || hs_hdr) && (pkt_done_q || hs_last))
          state_d = ST_IDLE;
      end
    endcase
  end

  // Routing is gated by rst_n so nothing handshakes while reset is held,
  // even though the state register only clears on the next edge.
  always_comb begin
    bus.s_ready_in      = '0;
    bus.s_ready_insert  = '0;
    bus.m_valid_in      = 1'b0;
    bus.m_data_in       = '0;
    bus.m_keep_in       = '0;
    bus.m_last_in       = 1'b0;
    bus.m_valid_insert  = 1'b0;
    bus.m_header_insert = '0;
    bus.m_keep_insert   = '0;
    if (rst_n && (state_q == ST_GRANT)) begin
      bus.m_valid_insert  = bus.s_valid_insert[grant_q] & ~hdr_done_q;
      bus.m_header_insert = bus.s_header_insert[int'(grant_q)*DATA_WD +: DATA_WD];
      bus.m_keep_insert   = bus.s_keep_insert[int'(grant_q)*DATA_BYTE_WD +: DATA_BYTE_WD];
      bus.s_ready_insert[grant_q] = bus.m_ready_insert & ~hdr_done_q;
      bus.m_valid_in      = bus.s_valid_in[grant_q] & ~pkt_done_q;
      bus.m_data_in       = bus.s_data_in[int'(grant_q)*DATA_WD +: DATA_WD];
      bus.m_keep_in       = bus.s_keep_in[int'(grant_q)*DATA_BYTE_WD +: DATA_BYTE_WD];
      bus.m_last_in       = bus.s_last_in[grant_q];
      bus.s_ready_in[grant_q] = bus.m_ready_in & ~pkt_done_q;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ST_GRANT);

endmodule

`default_nettype wire
